// File: rtl/ram_access_arbiter_pkg.sv
// Shared widths, RAM depth and requester identifiers for the RAM access arbiter.
package ram_arb_pkg;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 4;
    localparam int RAM_DEPTH = 16;

    typedef enum logic {HOST = 1'b0, SCAN = 1'b1} req_id_t;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/ram_access_arbiter_if.sv
// Host, scanner and single-port RAM signals of the arbiter; slave = arbiter side.
interface ram_access_arbiter_if;
    import ram_arb_pkg::*;

    logic  host_req;
    logic  host_we;
    addr_t host_addr;
    data_t host_wdata;
    logic  host_gnt;
    data_t host_rdata;
    logic  host_rvalid;
    logic  scan_en;
    data_t scan_data;
    addr_t scan_addr;
    logic  scan_valid;
    logic  frame_done;
    addr_t mem_addr;
    logic  mem_we;
    data_t mem_wdata;
    data_t mem_rdata;

    modport slave (
        input  host_req, host_we, host_addr, host_wdata, scan_en, mem_rdata,
        output host_gnt, host_rdata, host_rvalid, scan_data, scan_addr,
               scan_valid, frame_done, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output host_req, host_we, host_addr, host_wdata, scan_en, mem_rdata,
        input  host_gnt, host_rdata, host_rvalid, scan_data, scan_addr,
               scan_valid, frame_done, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/ram_access_arbiter_scan_addr_counter.sv
// Scanner address counter: advances on each scanner grant, wraps at the last RAM word.
module scan_addr_counter
    import ram_arb_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    output addr_t cnt,
    output logic  last
);
    assign last = (cnt == addr_t'(RAM_DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (en)
            cnt <= last ? '0 : cnt + addr_t'(1);
    end
endmodule

// File: rtl/ram_access_arbiter.sv
// Host/scanner arbiter for a single-port RAM; round-robin ties by default,
// host-always-wins when ARB_FIXED_PRIO_EN is defined.
module ram_access_arbiter
    import ram_arb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ram_access_arbiter_if.slave  bus
);
    req_id_t last_grant;
    addr_t   mem_addr_hold;
    addr_t   scan_cnt;
    logic    scan_last;
    logic    host_win;
    logic    scan_win;

    // Grants are suppressed while rst is high so no write can slip through.
    always_comb begin
        host_win = 1'b0;
        scan_win = 1'b0;
        if (!rst) begin
`ifdef ARB_FIXED_PRIO_EN
            host_win = bus.host_req;
`else
            host_win = bus.host_req && (!bus.scan_en || last_grant == SCAN);
`endif
            scan_win = bus.scan_en && !host_win;
        end
    end

    assign bus.host_gnt  = host_win;
    assign bus.mem_we    = host_win && bus.host_we;
    assign bus.mem_wdata = bus.host_wdata;
    assign bus.mem_addr  = host_win ? bus.host_addr :
                           scan_win ? scan_cnt      : mem_addr_hold;

    scan_addr_counter u_scan_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (scan_win),
        .cnt  (scan_cnt),
        .last (scan_last)
    );

    // Read results land one cycle after the grant cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant      <= SCAN;
            mem_addr_hold   <= '0;
            bus.host_rvalid <= 1'b0;
            bus.host_rdata  <= '0;
            bus.scan_valid  <= 1'b0;
            bus.scan_data   <= '0;
            bus.scan_addr   <= '0;
            bus.frame_done  <= 1'b0;
        end else begin
            bus.host_rvalid <= host_win && !bus.host_we;
            bus.scan_valid  <= scan_win;
            bus.frame_done  <= scan_win && scan_last;
            if (host_win && !bus.host_we)
                bus.host_rdata <= bus.mem_rdata;
            if (scan_win) begin
                bus.scan_data <= bus.mem_rdata;
                bus.scan_addr <= scan_cnt;
            end
            if (host_win || scan_win) begin
                last_grant    <= host_win ? HOST : SCAN;
                mem_addr_hold <= bus.mem_addr;
            end
        end
    end
endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: a behavioural model predicts grants
// and read results; a negedge monitor compares them against the DUT.
module tb_ram_access_arbiter;
    import ram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_access_arbiter_if bus();

    ram_access_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment RAM: combinational read, write at the clock edge.
    logic [3:0] ram_env [16];
    assign bus.mem_rdata = ram_env[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) ram_env[bus.mem_addr] <= bus.mem_wdata;

    typedef struct {logic h; logic s; logic we; logic [3:0] addr; logic [3:0] wdata;} gnt_t;
    typedef struct {logic [3:0] data; int due;} hrd_t;
    typedef struct {logic [3:0] addr; logic [3:0] data; logic fd; int due;} scn_t;

    gnt_t gnt_q[$];
    hrd_t host_q[$];
    scn_t scan_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fd_count = 0;

    logic [3:0] m_mem [16];
    bit         m_last_scan;
    int         m_cnt;
    logic [3:0] m_addr;
    bit         m_host_granted;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per cycle after inputs settle.
    task automatic model_step();
        gnt_t g;
        bit hw, sw;
        if (rst) begin
            host_q.delete();
            scan_q.delete();
            m_last_scan    = 1'b1;
            m_cnt          = 0;
            m_addr         = 4'd0;
            m_host_granted = 1'b0;
            g = '{h: 1'b0, s: 1'b0, we: 1'b0, addr: m_addr, wdata: 4'd0};
            gnt_q.push_back(g);
            return;
        end
`ifdef ARB_FIXED_PRIO_EN
        hw = bus.host_req;
`else
        hw = bus.host_req && (!bus.scan_en || m_last_scan);
`endif
        sw = bus.scan_en && !hw;
        if (hw) begin
            m_addr = bus.host_addr;
            if (bus.host_we) m_mem[bus.host_addr] = bus.host_wdata;
            else host_q.push_back('{data: m_mem[bus.host_addr], due: cyc + 1});
            m_last_scan = 1'b0;
        end else if (sw) begin
            m_addr = 4'(m_cnt);
            scan_q.push_back('{addr: 4'(m_cnt), data: m_mem[m_cnt], fd: (m_cnt == 15), due: cyc + 1});
            m_cnt = (m_cnt + 1) % 16;
            m_last_scan = 1'b1;
        end
        m_host_granted = hw;
        g = '{h: hw, s: sw, we: hw && bus.host_we, addr: m_addr, wdata: bus.host_wdata};
        gnt_q.push_back(g);
    endtask

    task automatic drive(input logic rs, input logic r, input logic we,
                         input logic [3:0] a, input logic [3:0] d, input logic se);
        @(posedge clk);
        #1;
        rst            = rs;
        bus.host_req   = r;
        bus.host_we    = we;
        bus.host_addr  = a;
        bus.host_wdata = d;
        bus.scan_en    = se;
        model_step();
    endtask

    always @(negedge clk) begin
        gnt_t g;
        if (gnt_q.size() > 0) begin
            g = gnt_q.pop_front();
            chk("host_gnt", 32'(bus.host_gnt), 32'(g.h));
            chk("mem_we",   32'(bus.mem_we),   32'(g.we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(g.addr));
            if (g.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(g.wdata));
        end
        if (host_q.size() > 0 && host_q[0].due == cyc) begin
            chk("host_rvalid", 32'(bus.host_rvalid), 32'd1);
            chk("host_rdata",  32'(bus.host_rdata),  32'(host_q[0].data));
            void'(host_q.pop_front());
        end else if (bus.host_rvalid) begin
            chk("host_rvalid_unexpected", 32'd1, 32'd0);
        end
        if (scan_q.size() > 0 && scan_q[0].due == cyc) begin
            chk("scan_valid", 32'(bus.scan_valid), 32'd1);
            chk("scan_addr",  32'(bus.scan_addr),  32'(scan_q[0].addr));
            chk("scan_data",  32'(bus.scan_data),  32'(scan_q[0].data));
            chk("frame_done", 32'(bus.frame_done), 32'(scan_q[0].fd));
            void'(scan_q.pop_front());
        end else begin
            if (bus.scan_valid) chk("scan_valid_unexpected", 32'd1, 32'd0);
            if (bus.frame_done) chk("frame_done_unexpected", 32'd1, 32'd0);
        end
        if (bus.frame_done) fd_count++;
    end

    initial begin
        bit         pend;
        logic       r, we, se;
        logic [3:0] a, d;

        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = 4'd0;
        bus.host_wdata = 4'd0; bus.scan_en = 1'b0;

        // Reset state
        repeat (3) drive(1, 1, 1, 4'd2, 4'd5, 1);
        @(negedge clk);
        chk("rst_mem_we",      32'(bus.mem_we),      32'd0);
        chk("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
        chk("rst_scan_valid",  32'(bus.scan_valid),  32'd0);
        chk("rst_frame_done",  32'(bus.frame_done),  32'd0);
        chk("rst_host_rdata",  32'(bus.host_rdata),  32'd0);
        chk("rst_scan_data",   32'(bus.scan_data),   32'd0);
        chk("rst_scan_addr",   32'(bus.scan_addr),   32'd0);

        // Host-only write then read of address 3
        drive(0, 1, 1, 4'd3, 4'hA, 0);
        drive(0, 1, 0, 4'd3, 4'h0, 0);
        drive(0, 0, 0, 4'd3, 4'h0, 0);
        @(negedge clk);
        chk("host_read_back", 32'(bus.host_rdata), 32'hA);

        // Preload value = address, then scan 17 words
        for (int i = 0; i < 16; i++) drive(0, 1, 1, 4'(i), 4'(i), 0);
        fd_count = 0;
        for (int i = 0; i < 17; i++) drive(0, 0, 0, 4'd0, 4'd0, 1);
        drive(0, 0, 0, 4'd0, 4'd0, 0);
        drive(0, 0, 0, 4'd0, 4'd0, 0);
        chk("frame_done_count", 32'(fd_count), 32'd1);

        // Contention from reset: host reads vs scanner
        drive(1, 0, 0, 4'd0, 4'd0, 0);
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 4'(i), 4'd0, 1);
        drive(0, 0, 0, 4'd0, 4'd0, 0);

        // Coherence: host writes addr 5 just before the scanner reads it
        drive(1, 0, 0, 4'd0, 4'd0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 4'd0, 4'd0, 1);
        drive(0, 1, 1, 4'd5, 4'h7, 0);
        drive(0, 0, 0, 4'd0, 4'd0, 1);
        drive(0, 0, 0, 4'd0, 4'd0, 0);
        @(negedge clk);
        chk("coherence_data", 32'(bus.scan_data), 32'h7);

        // Reset in the cycle after a host read grant aborts the rvalid
        drive(0, 1, 0, 4'd9, 4'd0, 0);
        drive(1, 0, 0, 4'd0, 4'd0, 0);
        @(negedge clk);
        chk("abort_rvalid", 32'(bus.host_rvalid), 32'd0);
        drive(0, 1, 0, 4'd9, 4'd0, 1);
        @(negedge clk);
        chk("first_tie_host", 32'(bus.host_gnt), 32'd1);
        drive(0, 0, 0, 4'd0, 4'd0, 1);
        drive(0, 0, 0, 4'd0, 4'd0, 0);

        // Randomized traffic; host holds its request until granted
        pend = 1'b0;
        r = 1'b0; we = 1'b0; a = 4'd0; d = 4'd0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                r  = ($urandom_range(0, 99) < 60);
                we = $urandom_range(0, 1) == 1;
                a  = 4'($urandom_range(0, 15));
                d  = 4'($urandom_range(0, 15));
            end
            se = ($urandom_range(0, 99) < 70);
            drive(0, r, we, a, d, se);
            pend = r && !m_host_granted;
        end
        repeat (3) drive(0, 0, 0, 4'd0, 4'd0, 0);
        @(negedge clk);
        chk("host_q_drained", 32'(host_q.size()), 32'd0);
        chk("scan_q_drained", 32'(scan_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_access_arbiter.md
RAM_ACCESS_ARBITER -- requirements
Module: ram_access_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-high reset, rst.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port host_req, input, 1 bit: host requests one RAM access this cycle.
REQ-005 Port host_we, input, 1 bit: selects the access type (1 = write, 0 = read).
REQ-006 Port host_addr, input, 4 bits; port host_wdata, input, 4 bits.
REQ-007 Port host_gnt, output, 1 bit: the host access is performed this cycle.
REQ-008 Port host_rdata, output, 4 bits, and port host_rvalid, output, 1 bit: read result, valid for one cycle.
REQ-009 Port scan_en, input, 1 bit: enables the sequential scanner requester.
REQ-010 Port scan_data, output, 4 bits, and port scan_addr, output, 4 bits: scanned word and its address.
REQ-011 Port scan_valid, output, 1 bit; port frame_done, output, 1 bit: pulse on scan of address 15.
REQ-012 Port mem_addr, output, 4 bits; port mem_we, output, 1 bit; port mem_wdata, output, 4 bits: single-port RAM drive.
REQ-013 Port mem_rdata, input, 4 bits: RAM combinational read data for mem_addr.

Function
REQ-014 Two requesters SHALL be arbitrated each cycle: host (host_req) and scanner (scan_en).
REQ-015 Arbitration SHALL be combinational from the requests and a registered last_grant flag; exactly one or zero grants per cycle.
REQ-016 Both requesting SHALL grant the requester not granted last (round-robin); a single requester SHALL always be granted.
REQ-017 last_grant SHALL update only on cycles with a grant.
REQ-018 On a host grant, mem_addr = host_addr, mem_we = host_we, mem_wdata = host_wdata, and host_gnt = 1 in the same cycle.
REQ-019 A host write SHALL commit at the end of the grant cycle; a host read SHALL register mem_rdata into host_rdata, with host_rvalid = 1 in the next cycle only.
REQ-020 The host SHALL hold host_req, host_we, host_addr and host_wdata stable until host_gnt; it may change them in the cycle after host_gnt.
REQ-021 On a scanner grant, mem_addr = scan counter, mem_we = 0, and the counter SHALL increment at the end of the cycle.
REQ-022 On a scanner grant, the next cycle SHALL have scan_valid = 1, scan_data = the read word, and scan_addr = the read address.
REQ-023 The scan counter SHALL wrap from 15 to 0.
REQ-024 frame_done SHALL pulse together with scan_valid when scan_addr = 15.
REQ-025 Deasserting scan_en SHALL hold the counter at its value, and reasserting it SHALL resume from that address.
REQ-026 With no grant, mem_we SHALL be 0 and mem_addr SHALL hold its previous value, with no side effects.
REQ-027 With both requesters continuously active, each SHALL be granted at least every 2nd cycle.

Reset
REQ-028 While rst = 1, the block SHALL clear host_rvalid, scan_valid and frame_done immediately and set mem_we = 0.
REQ-029 Reset SHALL also zero host_rdata, scan_data, scan_addr and the scan counter, and set last_grant = scanner (the host wins the first tie).
REQ-030 Reset mid-operation SHALL abort any pending rvalid or scan_valid, and the interrupted access SHALL NOT be acknowledged after release.

Configuration
REQ-031 With ARB_FIXED_PRIO_EN defined, the host SHALL always win when both request, and the scanner is granted only when host_req = 0.
REQ-032 Without ARB_FIXED_PRIO_EN, the round-robin of REQ-016 SHALL apply.

Structure
REQ-033 Package ram_arb_pkg SHALL hold ADDR_W = 4, DATA_W = 4, the requester-id typedef (HOST/SCAN) and the RAM depth constant 16.
REQ-034 Sub-module scan_addr_counter (enable, wrap, last-address flag) SHALL be instantiated once, and the arbiter logic stays in the top.

Verification
REQ-035 Host-only write: write addr 3 = 0xA, then read addr 3 -> host_gnt on each request cycle; host_rvalid 1 cycle after the read, host_rdata = 0xA.
REQ-036 Scan-only: preload 0..15 with value = addr; scan_en = 1 for 17 cycles -> scan_data = scan_addr sequence 0..15 then 0; frame_done exactly once at addr 15.
REQ-037 Contention: host_req = 1 (reads) and scan_en = 1 continuously after reset -> grants alternate H,S,H,S.
REQ-038 Contention under ARB_FIXED_PRIO_EN -> host granted every cycle; scan_valid never asserted.
REQ-039 Coherence: scanner at addr 5; host writes addr 5 = 0x7 before the scanner grant -> scan_data = 0x7 at scan_addr 5.
REQ-040 Reset pulse in the cycle after a host read grant -> host_rvalid stays 0; after release the scan counter = 0 and the first tie is granted to the host.
